// File: rtl/router_sync_n.sv
// rtl/router_sync_n.sv - N-channel router address synchroniser with per-channel read-timeout watchdog
module router_sync_n #(
   parameter int NUM_CH  = 3,
   parameter int ADDR_W  = 2,
   parameter int TIMEOUT = 30,
   parameter int CNT_W   = 5
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              detect_add,
   input  logic [ADDR_W-1:0] data,
   input  logic              write_enb_reg,
   input  logic [NUM_CH-1:0] full,
   input  logic [NUM_CH-1:0] empty,
   input  logic [NUM_CH-1:0] read_enb,
   output logic [NUM_CH-1:0] write_enb,
   output logic              fifo_full,
   output logic              fifo_empty,
   output logic [NUM_CH-1:0] vld_out,
   output logic [NUM_CH-1:0] soft_reset,
   output logic              addr_err
);

   localparam logic [ADDR_W:0]  NUM_CH_V = (ADDR_W+1)'(NUM_CH);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

   logic [ADDR_W-1:0] dest_q, dest_d;
   logic              dest_vld_q, dest_vld_d;
   logic              addr_err_q, addr_err_d;
   logic [CNT_W-1:0]  cnt_q [NUM_CH];
   logic [CNT_W-1:0]  cnt_d [NUM_CH];
   logic [NUM_CH-1:0] soft_reset_q, soft_reset_d;
   logic [NUM_CH-1:0] sel;

   always_comb begin
      dest_d     = dest_q;
      dest_vld_d = dest_vld_q;
      addr_err_d = addr_err_q;
      if (detect_add) begin
         dest_d     = data;
         dest_vld_d = 1'b1;
         addr_err_d = ({1'b0, data} >= NUM_CH_V);
      end
   end

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sel[i] = dest_vld_q && !addr_err_q && (dest_q == ADDR_W'(i));
      end
   end

   assign write_enb = sel & ~full & {NUM_CH{write_enb_reg}};
   assign vld_out   = ~empty;

   // A bad destination reports full+empty so the FSM stalls until the packet is dropped.
   always_comb begin
      fifo_full  = 1'b0;
      fifo_empty = 1'b1;
      if (addr_err_q) begin
         fifo_full  = 1'b1;
         fifo_empty = 1'b1;
      end else if (dest_vld_q) begin
         fifo_full  = |(full & sel);
         fifo_empty = |(empty & sel);
      end
   end

   always_comb begin
      soft_reset_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_d[i] = '0;
         if (vld_out[i] && !read_enb[i]) begin
            if (cnt_q[i] == TMO_LAST) begin
               soft_reset_d[i] = 1'b1;
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         dest_q       <= '0;
         dest_vld_q   <= 1'b0;
         addr_err_q   <= 1'b0;
         soft_reset_q <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         dest_q       <= dest_d;
         dest_vld_q   <= dest_vld_d;
         addr_err_q   <= addr_err_d;
         soft_reset_q <= soft_reset_d;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   assign soft_reset = soft_reset_q;
   assign addr_err   = addr_err_q;

endmodule

// File: doc/router_sync_n.md
# router_sync_n

Parametrised address synchroniser for the N-output router, the successor to the fixed three-channel synchroniser.
- Latches the destination address of each packet header and steers the packet FSM's write request to exactly one output FIFO.
- Muxes the selected FIFO's full/empty status back to the FSM and drives per-channel `vld_out`.
- Adds a per-channel read-timeout watchdog that issues `soft_reset` to a FIFO whose data is not drained.
- Sits between the router FSM, the input register and the NUM_CH output FIFOs.

## Interface
- `NUM_CH`, 3: number of output channels/FIFOs; 2..(2**ADDR_W).
- `ADDR_W`, 2: width of the header destination field.
- `TIMEOUT`, 30: consecutive stalled cycles before a channel soft reset; 2..(2**CNT_W).
- `CNT_W`, 5: width of each watchdog counter.

Ports:
- `clock`  in  1  single clock; all flops on rising edge.
- `resetn`  in  1  asynchronous, active-low reset; deassertion is synchronous to `clock` externally.
- `detect_add`  in  1  FSM strobe: `data` holds a header destination this cycle.
- `data`  in  ADDR_W  destination address, sampled only when `detect_add`=1.
- `write_enb_reg`  in  1  FSM request to write the current byte into the selected FIFO.
- `full`  in  NUM_CH  per-FIFO full flags.
- `empty`  in  NUM_CH  per-FIFO empty flags.
- `read_enb`  in  NUM_CH  per-channel read strobe from the downstream client.
- `write_enb`  out  NUM_CH  one-hot or zero FIFO write enable; bit i selects FIFO i.
- `fifo_full`  out  1  full flag of the selected FIFO.
- `fifo_empty`  out  1  empty flag of the selected FIFO.
- `vld_out`  out  NUM_CH  channel i has data.
- `soft_reset`  out  NUM_CH  one-cycle flush pulse to FIFO i.
- `addr_err`  out  1  latched destination is not a valid channel.

## Operation
- **Registers:** `dest` (ADDR_W), `dest_vld`, `addr_err`, per-channel `cnt[i]` (CNT_W) and `soft_reset[i]`. All reset to 0 asynchronously, at any point, including mid-packet.
- **Address capture:** on a rising edge with `detect_add`=1, `dest`<=`data` and `dest_vld`<=1. `addr_err`<=1 if `data` >= NUM_CH, else 0. Otherwise all three hold.
- **Selection:** "selected" means `dest_vld`=1, `addr_err`=0 and channel index == `dest`.
- **`write_enb[i]`** (combinational) = selected(i) AND `write_enb_reg` AND NOT `full[i]`. At most one bit is set. It is all-zero when nothing is selected.
- **`fifo_full` / `fifo_empty`** (combinational):
  - With a valid selection: `full[dest]` / `empty[dest]`.
  - When `addr_err`=1: 1 / 1, so the FSM stalls and the packet is dropped by upstream policy.
  - When `dest_vld`=0: 0 / 1.
- **`vld_out[i]`** (combinational) = NOT `empty[i]`, independent of selection.
- **Watchdog, per channel i, each rising edge:**
  - If `vld_out[i]`=1 AND `read_enb[i]`=0:
    - if `cnt[i]`==TIMEOUT-1, then `soft_reset[i]`<=1 and `cnt[i]`<=0;
    - else `cnt[i]`<=`cnt[i]`+1 and `soft_reset[i]`<=0.
  - Otherwise `cnt[i]`<=0 and `soft_reset[i]`<=0.
  - Net effect: `soft_reset[i]` is a single-cycle pulse and is never held high two consecutive cycles.
- **Independence:** channels time out independently; several `soft_reset` bits may pulse in the same cycle. A soft reset does not clear `dest`/`dest_vld`.
- **Width rule:** counter compare is unsigned at CNT_W bits; the increment never wraps because it is bounded by TIMEOUT-1.

## Timing
- **Address latency:** a new address takes effect on the cycle after the `detect_add` edge. If `detect_add` and `write_enb_reg` are both high in the same cycle, `write_enb` decodes the previous `dest` (header byte write is the FSM's next cycle).
- **Combinational paths:** `write_enb`, `fifo_full` and `fifo_empty` are zero-latency from `write_enb_reg`, `full` and `empty`. A FIFO going full in cycle t blocks `write_enb` in cycle t.
- **Timeout:** with `vld_out[i]`=1 and `read_enb[i]`=0 sampled on TIMEOUT consecutive edges, `soft_reset[i]` is high for the cycle following the TIMEOUT-th edge. A single `read_enb[i]`=1 edge restarts the count from 0.
- **Reset values:**
  - `write_enb`=0, `fifo_full`=0, `fifo_empty`=1, `soft_reset`=0, `addr_err`=0.
  - `vld_out` follows `empty` even while `resetn`=0.

## Test plan
- **Routing:** NUM_CH=3. Issue `detect_add` with `data`=2, then `write_enb_reg`=1 with `full`=000 → `write_enb`=100 (bit2 set) the following cycle. With `full[2]`=1 → `write_enb`=000 and `fifo_full`=1.
- **Back-to-back headers:** `data`=0 then `data`=1 on consecutive cycles, with `write_enb_reg` held high → `write_enb` bit0 for one cycle, then bit1. No cycle has two bits set.
- **Invalid address:** `data`=3 with NUM_CH=3 → `addr_err`=1, `fifo_full`=1, `write_enb`=0. A later `data`=1 clears `addr_err`.
- **Watchdog fire:** TIMEOUT=30, `empty[1]`=0, `read_enb[1]`=0 → `soft_reset[1]` high exactly one cycle, after the 30th edge. With `empty[1]` still 0, it pulses again 30 edges later.
- **Watchdog restart:** as in the watchdog-fire case, but pulse `read_enb[1]` at edge 29 → no pulse; the next pulse comes 30 edges after the read.
- **Async reset:** assert `resetn`=0 mid-packet, between clock edges → `write_enb`=0, `soft_reset`=0, `addr_err`=0 immediately. After release, no writes occur until a new `detect_add`.
